hazard_ctrl: RTL and testbench

// - Hazard/sequencing controller for the segmented MIPS pipeline (IF/ID/EX/MEM/WB).
// - Detects load-use hazards and stalls the front end; flushes wrong-path stages on taken branch/jump.
// - Freezes the whole pipeline while data memory is not ready; drives EX-stage forwarding selects.

---
 rtl/haz_pkg.sv | 30 +++
 rtl/fwd_unit.sv | 32 +++
 rtl/hazard_ctrl.sv | 160 ++++++++++++++++
 tb/tb_hazard_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/haz_pkg.sv
// Shared definitions for the MIPS pipeline hazard controller: control-word bit
// indices, forwarding select encodings and controller state encoding.
package haz_pkg;

    // ID/EX Control[9:0] bit positions
    localparam int unsigned CTL_SALTOINCOND = 9;
    localparam int unsigned CTL_REGDEST     = 8;
    localparam int unsigned CTL_FUENTEALU   = 7;
    localparam int unsigned CTL_MEMAREG     = 6;
    localparam int unsigned CTL_ESCRREG     = 5;
    localparam int unsigned CTL_LEERMEM     = 4;
    localparam int unsigned CTL_ESCRMEM     = 3;
    localparam int unsigned CTL_SALTOCOND   = 2;
    localparam int unsigned CTL_ALUOP_HI    = 1;
    localparam int unsigned CTL_ALUOP_LO    = 0;

    localparam logic [1:0] FWD_REG   = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

    // Stall countdown width; covers LOAD_STALL up to 7
    localparam int unsigned STALL_CNT_W = 3;

    typedef enum logic [1:0] {
        StRun    = 2'b00,
        StStall  = 2'b01,
        StFreeze = 2'b10
    } haz_state_e;

endpackage

// File: rtl/fwd_unit.sv
// EX-stage operand forwarding selects; EX/MEM result takes precedence over MEM/WB,
// and register 0 never forwards.
module fwd_unit
    import haz_pkg::*;
#(
    parameter int unsigned REG_W = 5
) (
    input  logic [REG_W-1:0] ex_rs_i,
    input  logic [REG_W-1:0] ex_rt_i,
    input  logic [REG_W-1:0] mem_rd_i,
    input  logic             mem_escr_reg_i,
    input  logic [REG_W-1:0] wb_rd_i,
    input  logic             wb_escr_reg_i,
    output logic [1:0]       fwd_a_o,
    output logic [1:0]       fwd_b_o
);

    function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] src);
        if (mem_escr_reg_i && (mem_rd_i != '0) && (mem_rd_i == src)) begin
            return FWD_EXMEM;
        end else if (wb_escr_reg_i && (wb_rd_i != '0) && (wb_rd_i == src)) begin
            return FWD_MEMWB;
        end
        return FWD_REG;
    endfunction

    always_comb begin
        fwd_a_o = fwd_sel(ex_rs_i);
        fwd_b_o = fwd_sel(ex_rt_i);
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/sequencing controller: load-use stalls, branch flush, memory freeze, forwarding.
// Define HAZARD_PERF_EN to add saturating stall/flush/freeze cycle counters.
module hazard_ctrl
    import haz_pkg::*;
#(
    parameter int unsigned LOAD_STALL = 1,
    parameter int unsigned REG_W      = 5
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             id_valid_i,
    input  logic [REG_W-1:0] id_rs_i,
    input  logic [REG_W-1:0] id_rt_i,
    input  logic [REG_W-1:0] ex_rs_i,
    input  logic [REG_W-1:0] ex_rt_i,
    input  logic [REG_W-1:0] ex_rd_i,
    input  logic             ex_escr_reg_i,
    input  logic             ex_leer_mem_i,
    input  logic [REG_W-1:0] mem_rd_i,
    input  logic             mem_escr_reg_i,
    input  logic [REG_W-1:0] wb_rd_i,
    input  logic             wb_escr_reg_i,
    input  logic             take_branch_i,
    input  logic             dmem_ready_i,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             idex_bubble_o,
    output logic             flush_front_o,
    output logic             freeze_all_o,
    output logic [1:0]       fwd_a_o,
    output logic [1:0]       fwd_b_o
`ifdef HAZARD_PERF_EN
    ,
    output logic [15:0]      stall_cnt_o,
    output logic [15:0]      flush_cnt_o,
    output logic [15:0]      freeze_cnt_o
`endif
);

    localparam logic [STALL_CNT_W-1:0] STALL_INIT = STALL_CNT_W'(LOAD_STALL - 1);
    localparam logic [STALL_CNT_W-1:0] STALL_LAST = STALL_CNT_W'(1);

    haz_state_e               state_q, state_d;
    haz_state_e               saved_q, saved_d;
    haz_state_e               eff_state;
    logic [STALL_CNT_W-1:0]   cnt_q, cnt_d;
    logic                     load_use;

    assign load_use = id_valid_i && ex_leer_mem_i && ex_escr_reg_i && (ex_rd_i != '0) &&
                      ((ex_rd_i == id_rs_i) || (ex_rd_i == id_rt_i));

    // Once memory is ready again, resume immediately as the state held before the freeze
    assign eff_state = (state_q == StFreeze) ? saved_q : state_q;

    always_comb begin
        pc_write_o    = 1'b1;
        ifid_write_o  = 1'b1;
        idex_bubble_o = 1'b0;
        flush_front_o = 1'b0;
        freeze_all_o  = 1'b0;
        state_d       = state_q;
        saved_d       = saved_q;
        cnt_d         = cnt_q;

        if (!dmem_ready_i) begin
            freeze_all_o = 1'b1;
            pc_write_o   = 1'b0;
            ifid_write_o = 1'b0;
            state_d      = StFreeze;
            if (state_q != StFreeze) begin
                saved_d = state_q;
            end
        end else if (take_branch_i) begin
            flush_front_o = 1'b1;
            cnt_d         = '0;
            state_d       = StRun;
        end else if (eff_state == StStall) begin
            pc_write_o    = 1'b0;
            ifid_write_o  = 1'b0;
            idex_bubble_o = 1'b1;
            cnt_d         = cnt_q - 1'b1;
            state_d       = (cnt_q == STALL_LAST) ? StRun : StStall;
        end else if (load_use) begin
            pc_write_o    = 1'b0;
            ifid_write_o  = 1'b0;
            idex_bubble_o = 1'b1;
            if (LOAD_STALL > 1) begin
                state_d = StStall;
                cnt_d   = STALL_INIT;
            end else begin
                state_d = StRun;
            end
        end else begin
            state_d = StRun;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StRun;
            saved_q <= StRun;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            saved_q <= saved_d;
            cnt_q   <= cnt_d;
        end
    end

    fwd_unit #(
        .REG_W (REG_W)
    ) u_fwd_unit (
        .ex_rs_i        (ex_rs_i),
        .ex_rt_i        (ex_rt_i),
        .mem_rd_i       (mem_rd_i),
        .mem_escr_reg_i (mem_escr_reg_i),
        .wb_rd_i        (wb_rd_i),
        .wb_escr_reg_i  (wb_escr_reg_i),
        .fwd_a_o        (fwd_a_o),
        .fwd_b_o        (fwd_b_o)
    );

`ifdef HAZARD_PERF_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;
    logic [15:0] freeze_cnt_q, freeze_cnt_d;

    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        freeze_cnt_d = freeze_cnt_q;
        if (idex_bubble_o && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
        if (flush_front_o && (flush_cnt_q != 16'hFFFF)) begin
            flush_cnt_d = flush_cnt_q + 16'd1;
        end
        if (freeze_all_o && (freeze_cnt_q != 16'hFFFF)) begin
            freeze_cnt_d = freeze_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
            freeze_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
            freeze_cnt_q <= freeze_cnt_d;
        end
    end

    assign stall_cnt_o  = stall_cnt_q;
    assign flush_cnt_o  = flush_cnt_q;
    assign freeze_cnt_o = freeze_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: LOAD_STALL=1 and LOAD_STALL=3 instances share stimulus and are
// checked every cycle against a bubbles-remaining model plus directed literal checks.
module tb_hazard_ctrl;

    localparam int unsigned REG_W = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_ni;
    logic             id_valid;
    logic [REG_W-1:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
    logic             ex_escr_reg, ex_leer_mem, mem_escr_reg, wb_escr_reg;
    logic             take_branch, dmem_ready;

    logic       pc_a, ifid_a, bub_a, fl_a, fz_a;
    logic       pc_b, ifid_b, bub_b, fl_b, fz_b;
    logic [1:0] fwda_a, fwdb_a, fwda_b, fwdb_b;
`ifdef HAZARD_PERF_EN
    logic [15:0] stc_a, flc_a, fzc_a, stc_b, flc_b, fzc_b;
    int m_st_a, m_st_b, m_fl, m_fz;
`endif

    int vectors = 0;
    int miscompares = 0;
    int left_a, left_b;  // bubbles still owed after the current cycle

    hazard_ctrl #(.LOAD_STALL(1), .REG_W(REG_W)) u_dut_a (
        .clk_i(clk), .rst_ni(rst_ni), .id_valid_i(id_valid), .id_rs_i(id_rs), .id_rt_i(id_rt),
        .ex_rs_i(ex_rs), .ex_rt_i(ex_rt), .ex_rd_i(ex_rd), .ex_escr_reg_i(ex_escr_reg),
        .ex_leer_mem_i(ex_leer_mem), .mem_rd_i(mem_rd), .mem_escr_reg_i(mem_escr_reg),
        .wb_rd_i(wb_rd), .wb_escr_reg_i(wb_escr_reg), .take_branch_i(take_branch),
        .dmem_ready_i(dmem_ready), .pc_write_o(pc_a), .ifid_write_o(ifid_a),
        .idex_bubble_o(bub_a), .flush_front_o(fl_a), .freeze_all_o(fz_a),
        .fwd_a_o(fwda_a), .fwd_b_o(fwdb_a)
`ifdef HAZARD_PERF_EN
        , .stall_cnt_o(stc_a), .flush_cnt_o(flc_a), .freeze_cnt_o(fzc_a)
`endif
    );

    hazard_ctrl #(.LOAD_STALL(3), .REG_W(REG_W)) u_dut_b (
        .clk_i(clk), .rst_ni(rst_ni), .id_valid_i(id_valid), .id_rs_i(id_rs), .id_rt_i(id_rt),
        .ex_rs_i(ex_rs), .ex_rt_i(ex_rt), .ex_rd_i(ex_rd), .ex_escr_reg_i(ex_escr_reg),
        .ex_leer_mem_i(ex_leer_mem), .mem_rd_i(mem_rd), .mem_escr_reg_i(mem_escr_reg),
        .wb_rd_i(wb_rd), .wb_escr_reg_i(wb_escr_reg), .take_branch_i(take_branch),
        .dmem_ready_i(dmem_ready), .pc_write_o(pc_b), .ifid_write_o(ifid_b),
        .idex_bubble_o(bub_b), .flush_front_o(fl_b), .freeze_all_o(fz_b),
        .fwd_a_o(fwda_b), .fwd_b_o(fwdb_b)
`ifdef HAZARD_PERF_EN
        , .stall_cnt_o(stc_b), .flush_cnt_o(flc_b), .freeze_cnt_o(fzc_b)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit lu_now();
        return id_valid && ex_leer_mem && ex_escr_reg && (ex_rd != 0) &&
               ((ex_rd == id_rs) || (ex_rd == id_rt));
    endfunction

    // {pc_write, ifid_write, idex_bubble, flush_front, freeze_all}
    function automatic logic [4:0] exp_ctl(input int left);
        if (!dmem_ready) return 5'b00001;
        if (take_branch) return 5'b11010;
        if (left > 0 || lu_now()) return 5'b00100;
        return 5'b11000;
    endfunction

    function automatic int next_left(input int left, input int ls);
        if (!dmem_ready) return left;
        if (take_branch) return 0;
        if (left > 0) return left - 1;
        if (lu_now()) return ls - 1;
        return 0;
    endfunction

    function automatic logic [1:0] exp_fwd(input logic [REG_W-1:0] src);
        if (mem_escr_reg && mem_rd != 0 && mem_rd == src) return 2'b10;
        if (wb_escr_reg && wb_rd != 0 && wb_rd == src) return 2'b01;
        return 2'b00;
    endfunction

    function automatic int sat_inc(input int v, input bit en);
        return (en && v < 65535) ? v + 1 : v;
    endfunction

    // Called at posedge+1; compares at posedge+5 with inputs settled
    task automatic step(input string tag);
        #4;
        chk({tag, " ctl(LS1)"}, {27'b0, pc_a, ifid_a, bub_a, fl_a, fz_a}, {27'b0, exp_ctl(left_a)});
        chk({tag, " ctl(LS3)"}, {27'b0, pc_b, ifid_b, bub_b, fl_b, fz_b}, {27'b0, exp_ctl(left_b)});
        chk({tag, " fwd(LS1)"}, {28'b0, fwda_a, fwdb_a}, {28'b0, exp_fwd(ex_rs), exp_fwd(ex_rt)});
        chk({tag, " fwd(LS3)"}, {28'b0, fwda_b, fwdb_b}, {28'b0, exp_fwd(ex_rs), exp_fwd(ex_rt)});
`ifdef HAZARD_PERF_EN
        chk({tag, " perf(LS1)"}, {stc_a, flc_a}, {m_st_a[15:0], m_fl[15:0]});
        chk({tag, " perf(LS3)"}, {stc_b, flc_b}, {m_st_b[15:0], m_fl[15:0]});
        chk({tag, " freeze_cnt"}, {fzc_a, fzc_b}, {m_fz[15:0], m_fz[15:0]});
`endif
    endtask

    task automatic tick();
        logic [4:0] ea, eb;
        ea = exp_ctl(left_a);
        eb = exp_ctl(left_b);
        @(posedge clk);
        if (rst_ni) begin
`ifdef HAZARD_PERF_EN
            m_st_a = sat_inc(m_st_a, ea[2]);
            m_st_b = sat_inc(m_st_b, eb[2]);
            m_fl   = sat_inc(m_fl, eb[1]);
            m_fz   = sat_inc(m_fz, eb[0]);
`endif
            left_a = next_left(left_a, 1);
            left_b = next_left(left_b, 3);
        end
        #1;
    endtask

    task automatic quiet();
        id_valid = 0; id_rs = 0; id_rt = 0; ex_rs = 0; ex_rt = 0; ex_rd = 0;
        ex_escr_reg = 0; ex_leer_mem = 0; mem_rd = 0; mem_escr_reg = 0;
        wb_rd = 0; wb_escr_reg = 0; take_branch = 0; dmem_ready = 1;
    endtask

    // lw $2 in EX, add $3,$2,$4 in ID
    task automatic set_lu();
        quiet();
        id_valid = 1; id_rs = 2; id_rt = 4; ex_rd = 2; ex_leer_mem = 1; ex_escr_reg = 1;
    endtask

    task automatic do_reset(input string tag);
        rst_ni = 0;
        quiet();
        left_a = 0; left_b = 0;
`ifdef HAZARD_PERF_EN
        m_st_a = 0; m_st_b = 0; m_fl = 0; m_fz = 0;
`endif
        step(tag);
        chk({tag, " lit ctl(LS3)"}, {27'b0, pc_b, ifid_b, bub_b, fl_b, fz_b}, 32'h18);
`ifdef HAZARD_PERF_EN
        chk({tag, " lit perf zero"}, {stc_b, flc_b}, 32'h0);
`endif
        tick();
        rst_ni = 1;
    endtask

    initial begin
        rst_ni = 0;
        quiet();
        left_a = 0; left_b = 0;
        @(posedge clk); #1;
        do_reset("reset");
        chk("reset lit fwd", {30'b0, fwda_a}, 32'h0);

        // Load-use with LOAD_STALL 1 and 3; branch aborts the longer stall
        set_lu(); step("lu1");
        chk("lu1 lit pc(LS1)", {31'b0, pc_a}, 32'h0);
        chk("lu1 lit bubble(LS1)", {31'b0, bub_a}, 32'h1);
        tick();
        quiet(); step("lu2");
        chk("lu2 lit pc(LS1)", {31'b0, pc_a}, 32'h1);
        chk("lu2 lit bubble(LS3)", {31'b0, bub_b}, 32'h1);
        tick();
        take_branch = 1; step("br");
        chk("br lit flush(LS3)", {30'b0, fl_b, bub_b}, 32'h2);
        tick();
        quiet(); step("after br");
        chk("after br lit(LS3)", {30'b0, pc_b, bub_b}, 32'h2);
        tick();

        // Exactly three bubbles for LOAD_STALL=3
        set_lu(); step("s3 c1"); chk("s3 c1 lit", {31'b0, bub_b}, 32'h1); tick();
        quiet();
        step("s3 c2"); chk("s3 c2 lit", {31'b0, bub_b}, 32'h1); tick();
        step("s3 c3"); chk("s3 c3 lit", {31'b0, bub_b}, 32'h1); tick();
        step("s3 c4"); chk("s3 c4 lit", {31'b0, bub_b}, 32'h0); tick();

        // Register 0 never stalls nor forwards
        quiet();
        id_valid = 1; ex_leer_mem = 1; ex_escr_reg = 1; mem_escr_reg = 1;
        step("r0"); chk("r0 lit", {29'b0, bub_a, fwda_a}, 32'h0); tick();

        // EX/MEM wins over MEM/WB
        quiet();
        mem_rd = 5; wb_rd = 5; mem_escr_reg = 1; wb_escr_reg = 1; ex_rs = 5;
        step("fwd mem"); chk("fwd mem lit", {30'b0, fwda_a}, 32'h2); tick();
        mem_escr_reg = 0;
        step("fwd wb"); chk("fwd wb lit", {30'b0, fwda_a}, 32'h1); tick();

        // Freeze for 4 cycles mid-stall, then the remaining two bubbles
        set_lu(); step("fz lu"); tick();
        quiet(); dmem_ready = 0;
        for (int i = 0; i < 4; i++) begin
            step("fz"); chk("fz lit", {30'b0, fz_b, pc_b}, 32'h2); tick();
        end
        dmem_ready = 1;
        step("fz r1"); chk("fz r1 lit", {31'b0, bub_b}, 32'h1); tick();
        step("fz r2"); chk("fz r2 lit", {31'b0, bub_b}, 32'h1); tick();
        step("fz r3"); chk("fz r3 lit", {31'b0, bub_b}, 32'h0); tick();

        // Reset mid-stall
        set_lu(); step("rs lu"); tick();
        do_reset("rst mid");

        for (int n = 0; n < 3000; n++) begin
            id_valid     = ($urandom_range(0, 3) != 0);
            id_rs        = REG_W'($urandom_range(0, 3));
            id_rt        = REG_W'($urandom_range(0, 3));
            ex_rs        = REG_W'($urandom_range(0, 3));
            ex_rt        = REG_W'($urandom_range(0, 3));
            ex_rd        = REG_W'($urandom_range(0, 3));
            mem_rd       = REG_W'($urandom_range(0, 3));
            wb_rd        = REG_W'($urandom_range(0, 3));
            ex_escr_reg  = $urandom_range(0, 1) == 1;
            ex_leer_mem  = $urandom_range(0, 1) == 1;
            mem_escr_reg = $urandom_range(0, 1) == 1;
            wb_escr_reg  = $urandom_range(0, 1) == 1;
            take_branch  = ($urandom_range(0, 9) == 0);
            dmem_ready   = ($urandom_range(0, 6) != 0);
            step("rand");
            tick();
            if ($urandom_range(0, 299) == 0) do_reset("rand rst");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
